// File: rtl/conv_channel_out_repeater.sv
// Feature-map replay buffer: captures one IMAGE_SIZE pixel map and streams it CHANNEL_NUM_OUT times.
// Optional macro CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN adds a second bank so filling overlaps replay.
module conv_channel_out_repeater #(
  parameter int DATA_WIDTH            = 32,
  parameter int IMAGE_SIZE            = 32*32,
  parameter int CHANNEL_NUM_OUT       = 256,
  parameter int POINTER_WIDTH         = $clog2(IMAGE_SIZE)+1,
  parameter int CNT_CHANNEL_OUT_WIDTH = $clog2(CHANNEL_NUM_OUT)+1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  input  logic [DATA_WIDTH-1:0]            pxl_in,
  output logic                             ready_in,
  output logic [DATA_WIDTH-1:0]            pxl_out,
  output logic                             valid_out,
  output logic [CNT_CHANNEL_OUT_WIDTH-1:0] ch_out,
  output logic                             last_pxl,
  output logic                             frame_last,
  output logic                             err_drop
);

  localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
  localparam int RAW   = AW + 1;
  localparam int DEPTH = 2**RAW;
`else
  localparam int RAW   = AW;
  localparam int DEPTH = IMAGE_SIZE;
`endif
  localparam logic [POINTER_WIDTH-1:0]         PTR_LAST = POINTER_WIDTH'(IMAGE_SIZE-1);
  localparam logic [CNT_CHANNEL_OUT_WIDTH-1:0] CH_LAST  = CNT_CHANNEL_OUT_WIDTH'(CHANNEL_NUM_OUT-1);

  typedef enum logic {FILL, REPLAY} state_e;

  state_e                           state_q, state_d;
  logic [POINTER_WIDTH-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_CHANNEL_OUT_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
  logic                             err_drop_q, err_drop_d;
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
  logic                             fill_bank_q, fill_bank_d, full_q, full_d;
`endif

  logic                             we, wr_last, replaying, rd_last, frame_end;
  logic [RAW-1:0]                   wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [DATA_WIDTH-1:0]            rd_data_q;

  logic                             s1_valid_q, s1_last_q, s1_frame_q;
  logic [CNT_CHANNEL_OUT_WIDTH-1:0] s1_ch_q;
  logic                             valid_out_q, last_pxl_q, frame_last_q;
  logic [DATA_WIDTH-1:0]            pxl_out_q;
  logic [CNT_CHANNEL_OUT_WIDTH-1:0] ch_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ch_cnt_q   <= '0;
      err_drop_q <= 1'b0;
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
      fill_bank_q <= 1'b0;
      full_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ch_cnt_q   <= ch_cnt_d;
      err_drop_q <= err_drop_d;
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
      fill_bank_q <= fill_bank_d;
      full_q      <= full_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ch_cnt_d   = ch_cnt_q;
    err_drop_d = err_drop_q | (valid_in & ~ready_in);
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
    fill_bank_d = fill_bank_q;
    full_d      = full_q;
`endif
    if (we) wr_ptr_d = wr_last ? '0 : wr_ptr_q + POINTER_WIDTH'(1);
    if (replaying) begin
      rd_ptr_d = rd_last ? '0 : rd_ptr_q + POINTER_WIDTH'(1);
      if (rd_last) ch_cnt_d = frame_end ? '0 : ch_cnt_q + CNT_CHANNEL_OUT_WIDTH'(1);
    end
    case (state_q)
      FILL: begin
        if (wr_last) begin
          state_d = REPLAY;
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
          fill_bank_d = ~fill_bank_q;
`endif
        end
      end
      REPLAY: begin
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
        if (wr_last) full_d = 1'b1;
        // A bank completing in the same cycle as the final read still swaps without a gap.
        if (frame_end) begin
          if (full_q || wr_last) begin
            fill_bank_d = ~fill_bank_q;
            full_d      = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
`else
        if (frame_end) state_d = FILL;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
`ifdef CONV_CHANNEL_OUT_REPEATER_PINGPONG_EN
    ready_in = ~full_q;
    wr_addr  = {fill_bank_q, wr_ptr_q[AW-1:0]};
    rd_addr  = {~fill_bank_q, rd_ptr_q[AW-1:0]};
`else
    ready_in = (state_q == FILL);
    wr_addr  = wr_ptr_q[AW-1:0];
    rd_addr  = rd_ptr_q[AW-1:0];
`endif
    we        = ready_in & valid_in;
    wr_last   = we && (wr_ptr_q == PTR_LAST);
    replaying = (state_q == REPLAY);
    rd_last   = replaying && (rd_ptr_q == PTR_LAST);
    frame_end = rd_last && (ch_cnt_q == CH_LAST);
  end

  // RAM kept reset-free so it maps onto block RAM; stale read data is masked at the output.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= pxl_in;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_frame_q   <= 1'b0;
      s1_ch_q      <= '0;
      valid_out_q  <= 1'b0;
      last_pxl_q   <= 1'b0;
      frame_last_q <= 1'b0;
      pxl_out_q    <= '0;
      ch_out_q     <= '0;
    end else begin
      s1_valid_q   <= replaying;
      s1_last_q    <= rd_last;
      s1_frame_q   <= frame_end;
      s1_ch_q      <= replaying ? ch_cnt_q : '0;
      valid_out_q  <= s1_valid_q;
      last_pxl_q   <= s1_last_q;
      frame_last_q <= s1_frame_q;
      pxl_out_q    <= s1_valid_q ? rd_data_q : '0;
      ch_out_q     <= s1_valid_q ? s1_ch_q : '0;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign ch_out     = ch_out_q;
  assign last_pxl   = last_pxl_q;
  assign frame_last = frame_last_q;
  assign err_drop   = err_drop_q;

endmodule

// File: tb/tb_conv_channel_out_repeater.sv
// Bench for conv_channel_out_repeater (single-bank build, IMAGE_SIZE=4, CHANNEL_NUM_OUT=3).
// A frame-level model schedules the expected output stream by cycle number; literal pins anchor it.
module tb_conv_channel_out_repeater;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int C  = 3;
  localparam int NC = N * C;
  localparam int CW = $clog2(C) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          ready_in, valid_out, last_pxl, frame_last, err_drop;
  logic [DW-1:0] pxl_out;
  logic [CW-1:0] ch_out;

  conv_channel_out_repeater #(
    .DATA_WIDTH(DW),
    .IMAGE_SIZE(N),
    .CHANNEL_NUM_OUT(C)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_in(ready_in), .pxl_out(pxl_out), .valid_out(valid_out), .ch_out(ch_out),
    .last_pxl(last_pxl), .frame_last(frame_last), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a completed map is replayed as NC outputs starting two edges after the final write edge.
  typedef struct { logic [DW-1:0] pxl; int ch; bit last; bit frame; } exp_t;
  exp_t          sched[int];
  logic [DW-1:0] img [N];
  int            m_cnt = 0;
  int            replay_until = -1;
  bit            m_ready = 1'b1;
  bit            m_err = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      m_cnt = 0;
      m_err = 1'b0;
      for (int k = cyc; k < cyc + NC + 4; k++) if (sched.exists(k)) sched.delete(k);
      replay_until = cyc - 1;
    end else if (valid_in) begin
      if (!m_ready) m_err = 1'b1;
      else begin
        img[m_cnt] = pxl_in;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0;
          for (int k = 0; k < NC; k++) begin
            e.pxl = img[k % N];
            e.ch = k / N;
            e.last = (k % N) == N - 1;
            e.frame = (k == NC - 1);
            sched[cyc + 2 + k] = e;
          end
          replay_until = cyc + NC - 1;
        end
      end
    end
    m_ready = cyc > replay_until;
  end

  logic [DW-1:0] cap_pxl[$];
  int            cap_ch[$];
  bit            cap_last[$];
  bit            cap_frame[$];
  int            cap_cyc[$];
  int            rdy_rise = 0;
  bit            prev_rdy = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    bit   v;
    if (cyc > 0) begin
      v = sched.exists(cyc);
      if (v) e = sched[cyc];
      else begin
        e.pxl = '0; e.ch = 0; e.last = 1'b0; e.frame = 1'b0;
      end
      chk("valid_out", 64'(valid_out), 64'(v));
      chk("pxl_out", 64'(pxl_out), 64'(e.pxl));
      chk("ch_out", 64'(ch_out), 64'(e.ch));
      chk("last_pxl", 64'(last_pxl), 64'(e.last));
      chk("frame_last", 64'(frame_last), 64'(e.frame));
      chk("ready_in", 64'(ready_in), 64'(m_ready));
      chk("err_drop", 64'(err_drop), 64'(m_err));
      if (valid_out) begin
        cap_pxl.push_back(pxl_out);
        cap_ch.push_back(int'(ch_out));
        cap_last.push_back(last_pxl);
        cap_frame.push_back(frame_last);
        cap_cyc.push_back(cyc);
      end
      if (ready_in && !prev_rdy) rdy_rise = cyc;
      prev_rdy = ready_in;
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] p);
    valid_in = v;
    pxl_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic clear_caps();
    cap_pxl.delete(); cap_ch.delete(); cap_last.delete(); cap_frame.delete(); cap_cyc.delete();
  endtask

  int wr;
  int exp_p1[NC] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
  int exp_ch[NC] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int exp_p2[NC] = '{9, 8, 7, 6, 9, 8, 7, 6, 9, 8, 7, 6};
  int exp_p4[NC] = '{5, 6, 7, 8, 5, 6, 7, 8, 5, 6, 7, 8};
  bit bub[7] = '{1, 0, 1, 0, 0, 1, 1};
  int bdat[4] = '{9, 8, 7, 6};

  initial begin
    int j;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(ready_in), 64'd1);
    chk("rst_pxl", 64'(pxl_out), 64'd0);
    reset = 1'b0;

    // Contiguous fill
    clear_caps();
    for (int i = 1; i <= N; i++) drive(1'b1, DW'(i));
    wr = cyc;
    idle(NC + 4);
    chk("t1_count", 64'(cap_pxl.size()), 64'd12);
    // edge-indexed: visible after edge wr+2, i.e. 3 cycles after the write cycle
    chk("t1_latency", 64'(cap_cyc[0] - wr), 64'd2);
    chk("t1_ready_rise", 64'(rdy_rise - wr), 64'd12);
    for (int i = 0; i < NC; i++) begin
      chk("t1_pxl", 64'(cap_pxl[i]), 64'(exp_p1[i]));
      chk("t1_ch", 64'(cap_ch[i]), 64'(exp_ch[i]));
    end
    chk("t1_last4", 64'(cap_last[3]), 64'd1);
    chk("t1_last8", 64'(cap_last[7]), 64'd1);
    chk("t1_frame8", 64'(cap_frame[7]), 64'd0);
    chk("t1_frame12", 64'(cap_frame[11]), 64'd1);

    // Fill with bubbles
    clear_caps();
    j = 0;
    for (int i = 0; i < 7; i++) begin
      if (bub[i]) begin
        drive(1'b1, DW'(bdat[j]));
        j++;
      end else drive(1'b0, 32'hFFFF_FFFF);
    end
    wr = cyc;
    idle(NC + 4);
    chk("t2_count", 64'(cap_pxl.size()), 64'd12);
    chk("t2_latency", 64'(cap_cyc[0] - wr), 64'd2);
    for (int i = 0; i < NC; i++) chk("t2_pxl", 64'(cap_pxl[i]), 64'(exp_p2[i]));

    // Drops mid-replay and on the final read cycle
    for (int i = 1; i <= N; i++) drive(1'b1, DW'(i));
    idle(3);
    drive(1'b1, 32'h0000_DEAD);
    idle(7);
    drive(1'b1, 32'h0000_DEAD);
    chk("t3_err", 64'(err_drop), 64'd1);
    for (int i = 10; i <= 13; i++) drive(1'b1, DW'(i));
    clear_caps();
    idle(NC + 4);
    chk("t3_err_sticky", 64'(err_drop), 64'd1);
    chk("t3_count", 64'(cap_pxl.size()), 64'd12);
    for (int i = 0; i < N; i++) chk("t3_pxl", 64'(cap_pxl[i]), 64'(10 + i));

    // Reset during second replay
    for (int i = 1; i <= N; i++) drive(1'b1, DW'(i));
    idle(6);
    reset = 1'b1;
    drive(1'b0, '0);
    reset = 1'b0;
    chk("t4_valid", 64'(valid_out), 64'd0);
    chk("t4_ready", 64'(ready_in), 64'd1);
    chk("t4_err", 64'(err_drop), 64'd0);
    clear_caps();
    for (int i = 5; i <= 8; i++) drive(1'b1, DW'(i));
    idle(NC + 4);
    chk("t4_count", 64'(cap_pxl.size()), 64'd12);
    for (int i = 0; i < NC; i++) chk("t4_pxl", 64'(cap_pxl[i]), 64'(exp_p4[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
